// File: rtl/p2s_pkg.sv
// Shared definitions for the serializer and its serial-to-parallel partner stage.
// State encoding, default word width and the bit-counter sizing helper.
package p2s_pkg;

    localparam int P2S_DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    // Width of a counter that must reach w-1; never below one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/p2s_bitcnt.sv
// Bit-index counter: holds when not advancing, clears on load, wraps after WIDTH-1.
// Zero latency on o_last; no backpressure of its own.
module p2s_bitcnt import p2s_pkg::*; #(
    parameter int WIDTH = P2S_DEFAULT_WIDTH,
    localparam int CW   = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] r_idx;

    assign o_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_adv) begin
            r_idx <= o_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/p2s.sv
// Parallel-to-serial shifter: one word in via din_valid/din_ready, one bit out per enabled cycle.
// First bit one cycle after acceptance; din_ready only in IDLE or on the last enabled bit, else upstream stalls.
module p2s import p2s_pkg::*; #(
    parameter int WIDTH     = P2S_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_vld,
    output logic             done
);

    p2s_state_t       r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_sout;
    logic             r_sout_vld;
    logic             r_done;

    logic             w_last;
    logic             w_adv;
    logic             w_ready;
    logic             w_accept;
    logic             w_first;
    logic             w_next;
    logic [WIDTH-1:0] w_shifted;

    assign w_adv     = (r_state == SHIFT) && en;
    assign w_ready   = !reset && ((r_state == IDLE) || (w_adv && w_last));
    assign w_accept  = din_valid && w_ready;

    // r_word is kept aligned so the bit after the one on sout always sits next to the head.
    assign w_first   = MSB_FIRST ? din[WIDTH-1]    : din[0];
    assign w_next    = MSB_FIRST ? r_word[WIDTH-2] : r_word[1];
    assign w_shifted = MSB_FIRST ? (r_word << 1)   : (r_word >> 1);

    p2s_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_accept),
        .i_adv  (w_adv),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_sout     <= 1'b0;
            r_sout_vld <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_adv && w_last;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= SHIFT;
                        r_word     <= din;
                        r_sout     <= w_first;
                        r_sout_vld <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (!w_last) begin
                            r_word <= w_shifted;
                            r_sout <= w_next;
                        end else if (w_accept) begin
                            r_word <= din;
                            r_sout <= w_first;
                        end else begin
                            r_state    <= IDLE;
                            r_word     <= '0;
                            r_sout     <= 1'b0;
                            r_sout_vld <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign din_ready = w_ready;
    assign sout      = r_sout;
    assign sout_vld  = r_sout_vld;
    assign done      = r_done;

endmodule

// File: tb/tb_p2s.sv
// Scoreboard bench for p2s: MSB-first and LSB-first instances share stimulus.
// Expected bits are queued at acceptance; a negedge monitor checks ready, bits, valid and done.
module tb_p2s;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         en;
    logic         din_ready, sout, sout_vld, done;
    logic         din_ready_l, sout_l, sout_vld_l, done_l;

    p2s #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .en        (en),
        .sout      (sout),
        .sout_vld  (sout_vld),
        .done      (done)
    );

    p2s #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready_l),
        .en        (en),
        .sout      (sout_l),
        .sout_vld  (sout_vld_l),
        .done      (done_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         b;
        bit           last;
        logic [W-1:0] word;
    } exp_bit_t;

    exp_bit_t     q_msb[$];
    exp_bit_t     q_lsb[$];
    exp_bit_t     mon_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           exp_done = 1'b0;
    logic [W-1:0] exp_done_word = '0;
    logic [W-1:0] pout;
    bit           rnd_en = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void push_word(input logic [W-1:0] w);
        exp_bit_t e;
        for (int i = 0; i < W; i++) begin
            e.last = (i == W - 1);
            e.word = w;
            e.b    = w[W-1-i];
            q_msb.push_back(e);
            e.b    = w[i];
            q_lsb.push_back(e);
        end
    endfunction

    // Downstream serial-to-parallel stage; it shares the advance enable so held bits are taken once.
    always @(posedge clk or posedge reset) begin
        if (reset) pout <= '0;
        else if (sout_vld && en) pout <= {pout[W-2:0], sout};
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk1("din_ready",    din_ready,   (q_msb.size() == 0) || (q_msb.size() == 1 && en));
            chk1("din_ready_lsb", din_ready_l, (q_lsb.size() == 0) || (q_lsb.size() == 1 && en));
            chk1("sout_vld",     sout_vld,    q_msb.size() != 0);
            chk1("sout",         sout,        (q_msb.size() != 0) ? q_msb[0].b : 1'b0);
            chk1("sout_vld_lsb", sout_vld_l,  q_lsb.size() != 0);
            chk1("sout_lsb",     sout_l,      (q_lsb.size() != 0) ? q_lsb[0].b : 1'b0);
            chk1("done",         done,        exp_done);
            chk1("done_lsb",     done_l,      exp_done);
            if (exp_done) chkn("pout", 32'(pout), 32'(exp_done_word));
            exp_done = 1'b0;
            if (q_msb.size() != 0 && en) begin
                mon_e = q_msb.pop_front();
                if (mon_e.last) begin
                    exp_done      = 1'b1;
                    exp_done_word = mon_e.word;
                end
            end
            if (q_lsb.size() != 0 && en) void'(q_lsb.pop_front());
        end
    end

    // Called just after a rising edge; drives one cycle of inputs and records acceptance.
    task automatic tick(input bit v, input logic [W-1:0] d, input bit e, output bit acc);
        din_valid = v;
        din       = d;
        en        = rnd_en ? ($urandom_range(0, 2) != 0) : e;
        @(negedge clk);
        acc = v && din_ready;
        @(posedge clk);
        #1;
        if (acc) push_word(d);
    endtask

    task automatic idle(input int n, input bit e);
        bit a;
        repeat (n) tick(1'b0, '0, e, a);
    endtask

    task automatic send(input logic [W-1:0] w, input bit e);
        bit acc = 1'b0;
        int t   = 0;
        while (!acc && t < 40) begin
            tick(1'b1, w, e, acc);
            t++;
        end
        din_valid = 1'b0;
        chk1("send_accepted", acc, 1'b1);
    endtask

    task automatic drain(input bit e);
        bit a;
        int t = 0;
        while (q_msb.size() != 0 && t < 80) begin
            tick(1'b0, '0, e, a);
            t++;
        end
        chkn("drain_empty", q_msb.size(), 0);
        idle(2, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b0;
        #2;
        chk1("rst_sout",      sout,        1'b0);
        chk1("rst_sout_vld",  sout_vld,    1'b0);
        chk1("rst_done",      done,        1'b0);
        chk1("rst_din_ready", din_ready,   1'b0);
        chk1("rst_ready_lsb", din_ready_l, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("ready_after_reset", din_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word, en held high: 1,0,1,0 then done.
        send(4'b1010, 1'b1);
        idle(6, 1'b1);

        // Second bit held for two extra cycles.
        send(4'b1010, 1'b1);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Back-to-back with din_valid held; reload on the last bit without a gap.
        send(4'b1100, 1'b1);
        send(4'b0011, 1'b1);
        drain(1'b1);

        // LSB-first instance must show 1,0,0,0.
        send(4'b0001, 1'b1);
        drain(1'b1);

        // en low in IDLE still accepts; first bit waits on sout.
        send(4'b1001, 1'b0);
        idle(2, 1'b0);
        drain(1'b1);

        // Reset while showing bit index 2: partial word dropped, no done.
        send(4'b1010, 1'b1);
        idle(2, 1'b1);
        reset = 1'b1;
        q_msb.delete();
        q_lsb.delete();
        exp_done = 1'b0;
        #1;
        chk1("midrst_sout",      sout,      1'b0);
        chk1("midrst_sout_vld",  sout_vld,  1'b0);
        chk1("midrst_din_ready", din_ready, 1'b0);
        chk1("midrst_done",      done,      1'b0);
        chk1("midrst_sout_lsb",  sout_l,    1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3, 1'b1);

        // Loopback with random enable gaps.
        rnd_en = 1'b1;
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        send(4'hF, 1'b1);
        drain(1'b1);
        rnd_en = 1'b0;
        idle(2, 1'b1);

        chkn("lsb_queue_empty", q_lsb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/p2s.md
P2S -- requirements
Module: p2s

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is serialized first; 0 = bit 0 first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block accepts din on this cycle.
REQ-008 en  input  1  advance enable; 0 freezes the serializer in place.
REQ-009 sout  output  1  current serial bit.
REQ-010 sout_vld  output  1  sout carries a valid bit this cycle; intended to drive the downstream serial-to-parallel en input.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-012 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; no other condition loads din.
REQ-013 FSM states SHALL be IDLE (no word held) and SHIFT (word held, bit index 0..WIDTH-1).
REQ-014 IDLE: din_ready=1, sout_vld=0, sout=0. Acceptance -> SHIFT, bit index 0.
REQ-015 SHIFT: sout_vld=1; sout = held word bit at the current index, in the order MSB_FIRST selects.
REQ-016 Latency SHALL be one cycle: the first bit appears on sout the cycle after acceptance.
REQ-017 In SHIFT with en=1, the bit index SHALL advance by one per cycle; with en=0, index, sout and sout_vld SHALL hold unchanged.
REQ-018 din_ready in SHIFT SHALL be 1 only when index=WIDTH-1 and en=1; this is a combinational function of state and en.
REQ-019 Last bit with en=1 and a word accepted: the block SHALL stay in SHIFT, reload and set index 0, with no gap cycle and no done-induced bubble.
REQ-020 Last bit with en=1 and no word accepted: the block SHALL return to IDLE.
REQ-021 done SHALL pulse high for exactly one cycle on the cycle after the last bit is consumed (last index, en=1), including in back-to-back transfers.
REQ-022 din_valid=1 while din_ready=0 SHALL have no effect; the upstream holds the word until accepted.
REQ-023 en=0 in IDLE SHALL NOT block acceptance; the first bit then waits on sout until en=1.
REQ-024 The bit counter SHALL be $clog2(WIDTH) bits and SHALL never exceed WIDTH-1.

Reset
REQ-025 While reset=1: state=IDLE, index=0, held word=0, sout=0, sout_vld=0, done=0, din_ready=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; no done is issued for it.
REQ-027 On the first rising edge after reset deasserts, the block SHALL be in IDLE with din_ready=1.

Structure
REQ-028 Shared package p2s_pkg SHALL hold the FSM state encoding (IDLE, SHIFT) and the default WIDTH constant shared with the serial-to-parallel stage.
REQ-029 One sub-module, p2s_bitcnt (bit-index counter with en hold, clear and wrap-at-WIDTH-1 flag), is natural; everything else stays in p2s.

Verification
REQ-030 Reset pulse during SHIFT at index 2 -> sout=0, sout_vld=0 immediately; IDLE and din_ready=1 after release; no done.
REQ-031 WIDTH=4, MSB_FIRST=1, din=4'b1010 accepted, en=1 held -> sout 1,0,1,0 on cycles 1-4, sout_vld high for 4 cycles, done on cycle 5.
REQ-032 Same word with en=0 for 2 cycles after the second bit -> sout holds 0 for 3 cycles, then 1,0 follow; done delayed by 2 cycles.
REQ-033 Back-to-back 4'b1100 then 4'b0011 with din_valid held high -> 8 consecutive sout_vld cycles (1,1,0,0,0,0,1,1), done pulses on cycles 5 and 9.
REQ-034 MSB_FIRST=0, din=4'b0001 -> sout 1,0,0,0.
REQ-035 Loopback into the serial-to-parallel stage (sout->sin, sout_vld->en), words 4'hA, 4'h5, 4'hF with random en gaps -> pout matches each word when its done pulses.
